piece_bag_generator: RTL and testbench
======================================

// Module: piece_bag_generator
// PURPOSE
//  Responder to the game loop's piece-order handshake. On iGenerate, shuffles the 7 tetromino IDs (0..6) into a
//  fresh random bag with a cycle-stepped Fisher-Yates shuffle driven by a free-running LFSR, then pulses oGenDone.
//  The bag is read combinationally by iIndex while the game loop walks through pieces 0..6.
// PARAMETERS
//  LFSR_SEED  16'hACE1  reset value of 16-bit LFSR; 16'h0000 replaced by 16'h0001
//  LFSR_TAPS  16'hB400  Galois feedback mask
// PORTS
//  clk        in   1  clock
//  iReset     in   1  synchronous, active-high reset
//  iEn        in   1  global enable; low = freeze all state incl. LFSR
//  iGenerate  in   1  level request, held high by game loop until oGenDone seen
//  iIndex     in   3  bag read index 0..6
//  oPiece     out  3  bag[iIndex]; 3'd7 when iIndex==7
//  oGenDone   out  1  high exactly one enabled cycle (DONE state) when bag valid
//  oBusy      out  1  high in INIT/PICK/SWAP/DONE
// BEHAVIOUR
//  Reset: state IDLE, bag = {0,1,2,3,4,5,6} (bag[k]=k), i=6, j=0, lfsr=LFSR_SEED; oGenDone=0, oBusy=0,
//   oPiece=iIndex (7 for idx 7).
//  LFSR: every enabled cycle in every state: lfsr <= (lfsr>>1) ^ (lfsr[0] ? LFSR_TAPS : 0). r = lfsr[2:0].
//  FSM (advances only when iEn=1; outputs decoded from state):
//   IDLE : iGenerate=1 -> INIT, else stay.
//   INIT : bag <= identity, i <= 6 -> PICK.
//   PICK : if r <= i {j <= r; -> SWAP} else stay (retry next cycle with new r).
//   SWAP : bag[i] <= bag[j], bag[j] <= bag[i] (j==i = no change); i==1 -> DONE, else i <= i-1, -> PICK.
//   DONE : oGenDone=1 -> IDLE unconditionally.
//  Latency: request sampled in IDLE at cycle 0 -> oGenDone at cycle 14 + R, R = total PICK rejections.
//  iGenerate during INIT/PICK/SWAP/DONE ignored; still high in IDLE after DONE -> new shuffle.
//  oPiece combinational from bag regs; valid only while oBusy=0 or in DONE; mid-shuffle values transient.
//  iEn=0: state, i, j, bag, lfsr hold; oGenDone/oBusy hold their decoded values.
//  Reset mid-shuffle: immediate return to reset values; no oGenDone issued.
//  Result is always a permutation of 0..6; no duplicate or missing ID at DONE.
// TESTING
//  1 Reset, no request, iIndex 0..7 -> oPiece 0,1,2,3,4,5,6,7; oGenDone=0, oBusy=0 throughout.
//  2 LFSR_TAPS=0, LFSR_SEED=1; iGenerate high 1 cycle after reset (r=0 every PICK) -> oGenDone exactly 14 cycles
//    after IDLE sample, one cycle wide; bag = {1,2,3,4,5,6,0}; iGenerate dropped next cycle -> stays IDLE.
//  3 Default params, 200 back-to-back bags via game-loop model -> each bag a permutation of 0..6, latency =
//    14 + R vs bench LFSR model, oGenDone single-cycle each time.
//  4 iEn low 5 cycles mid-PICK -> bag, i, lfsr unchanged during stall; final bag and latency (+5) match model.
//  5 iReset pulse during SWAP with i=3 -> next cycle IDLE, oBusy=0, bag identity, lfsr=LFSR_SEED, no oGenDone.
//  6 LFSR_SEED=16'h0000 -> first enabled cycle lfsr shifts from 16'h0001 (no lock-up); shuffle completes.

Source files
------------

// File: rtl/piece_bag_generator.sv
// piece_bag_generator
//   Answers the game loop's piece-order request. On iGenerate the seven
//   tetromino IDs (0..6) are shuffled into a fresh bag by a Fisher-Yates
//   shuffle that takes one PICK/SWAP step pair per position. Random draws
//   come from a free-running Galois LFSR, and oGenDone pulses when the bag
//   is ready. The game loop then reads the bag combinationally through
//   iIndex.
//
// Ports
//   clk        clock
//   iReset     synchronous, active-high reset
//   iEn        global enable; low freezes every register including the LFSR
//   iGenerate  level request, held by the game loop until oGenDone is seen
//   iIndex     bag read index 0..6 (7 reads back 7)
//   oPiece     bag[iIndex]
//   oGenDone   high for the single DONE cycle
//   oBusy      high in INIT/PICK/SWAP/DONE
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for iGenerate; bag holds the last result
// INIT  | reload identity bag, i = 6
// PICK  | draw r = lfsr[2:0]; accept as j when r <= i, else retry
// SWAP  | exchange bag[i] and bag[j]; step i down or finish at i == 1
// DONE  | bag valid, oGenDone pulse
module piece_bag_generator #(
   parameter logic [15:0] LFSR_SEED = 16'hACE1,
   parameter logic [15:0] LFSR_TAPS = 16'hB400
) (
   input  logic       clk,
   input  logic       iReset,
   input  logic       iEn,
   input  logic       iGenerate,
   input  logic [2:0] iIndex,
   output logic [2:0] oPiece,
   output logic       oGenDone,
   output logic       oBusy
);

   // An all-zero seed would lock the LFSR at zero.
   localparam logic [15:0] SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

   typedef enum logic [2:0] {IDLE, INIT, PICK, SWAP, DONE} state_t;

   state_t      state;
   state_t      stateNext;
   logic [15:0] lfsr;
   logic [2:0]  bag [8];
   logic [2:0]  pickI;
   logic [2:0]  pickJ;
   logic [2:0]  r;
   logic        accept;

   assign r      = lfsr[2:0];
   assign accept = (r <= pickI);

   // Entry 7 always holds 7, so an index of 7 reads back 7 without a special case.
   assign oPiece = bag[iIndex];

   always_ff @(posedge clk) begin
      if (iReset) begin
         state <= IDLE;
      end else if (iEn) begin
         state <= stateNext;
      end
   end

   always_comb begin
      stateNext = state;
      oGenDone  = 1'b0;
      oBusy     = 1'b1;
      case (state)
         IDLE: begin
            oBusy = 1'b0;
            if (iGenerate) stateNext = INIT;
         end
         INIT: stateNext = PICK;
         PICK: if (accept) stateNext = SWAP;
         SWAP: stateNext = (pickI == 3'd1) ? DONE : PICK;
         DONE: begin
            oGenDone  = 1'b1;
            stateNext = IDLE;
         end
         default: begin
            oBusy     = 1'b0;
            stateNext = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (iReset) begin
         lfsr  <= SEED_EFF;
         pickI <= 3'd6;
         pickJ <= 3'd0;
         for (int k = 0; k < 8; k++) bag[k] <= 3'(k);
      end else if (iEn) begin
         lfsr <= (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
         case (state)
            INIT: begin
               pickI <= 3'd6;
               for (int k = 0; k < 8; k++) bag[k] <= 3'(k);
            end
            PICK: if (accept) pickJ <= r;
            SWAP: begin
               // When j == i both writes carry the same value, so the bag is unchanged.
               bag[pickI] <= bag[pickJ];
               bag[pickJ] <= bag[pickI];
               if (pickI != 3'd1) pickI <= pickI - 3'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_piece_bag_generator.sv
// Testbench for piece_bag_generator. Three instances are used: default
// parameters, a zero-tap LFSR with seed 1 (r is always 0), and an
// all-zero seed. Expected bags and latencies come from a reference
// Fisher-Yates shuffle that walks the LFSR sequence.
module tb_piece_bag_generator;

   logic clk = 1'b0;
   always #10 clk = ~clk;

   logic       rst  [3];
   logic       en   [3];
   logic       gen  [3];
   logic [2:0] idx  [3];
   logic [2:0] piece[3];
   logic       done [3];
   logic       busy [3];

   piece_bag_generator dutMain (
      .clk(clk), .iReset(rst[0]), .iEn(en[0]), .iGenerate(gen[0]), .iIndex(idx[0]),
      .oPiece(piece[0]), .oGenDone(done[0]), .oBusy(busy[0]));

   piece_bag_generator #(.LFSR_SEED(16'h0001), .LFSR_TAPS(16'h0000)) dutZero (
      .clk(clk), .iReset(rst[1]), .iEn(en[1]), .iGenerate(gen[1]), .iIndex(idx[1]),
      .oPiece(piece[1]), .oGenDone(done[1]), .oBusy(busy[1]));

   piece_bag_generator #(.LFSR_SEED(16'h0000)) dutSeed (
      .clk(clk), .iReset(rst[2]), .iEn(en[2]), .iGenerate(gen[2]), .iIndex(idx[2]),
      .oPiece(piece[2]), .oGenDone(done[2]), .oBusy(busy[2]));

   int nTests = 0;
   int nFail  = 0;
   int expLat;
   int lastLat;
   logic [6:0][2:0] expBag;
   logic [6:0][2:0] obsBag;
   logic [15:0] mLfsr [3];

   function automatic logic [15:0] tapsOf(input int d);
      return (d == 1) ? 16'h0000 : 16'hB400;
   endfunction

   function automatic logic [15:0] seedOf(input int d);
      return (d == 0) ? 16'hACE1 : 16'h0001;
   endfunction

   function automatic logic [15:0] stepL(input logic [15:0] l, input logic [15:0] t);
      return (l >> 1) ^ (l[0] ? t : 16'h0000);
   endfunction

   function automatic logic [15:0] getLfsr(input int d);
      case (d)
         0:       return dutMain.lfsr;
         1:       return dutZero.lfsr;
         default: return dutSeed.lfsr;
      endcase
   endfunction

   function automatic bit isPerm(input logic [6:0][2:0] b);
      logic [7:0] m;
      m = '0;
      for (int k = 0; k < 7; k++) m[b[k]] = 1'b1;
      return (m == 8'h7F);
   endfunction

   // Reference LFSR: advances on every enabled edge, reloads on reset.
   always @(posedge clk) begin
      for (int d = 0; d < 3; d++) begin
         if (rst[d])     mLfsr[d] <= seedOf(d);
         else if (en[d]) mLfsr[d] <= stepL(mLfsr[d], tapsOf(d));
      end
   end

   // The LFSR value in the IDLE cycle that samples the request is cycle 0.
   // The first draw happens in cycle 2. A rejected draw costs one cycle, and
   // an accepted one costs PICK + SWAP (two cycles).
   task automatic predict(input int d);
      logic [15:0] l;
      logic [2:0]  tmp;
      int t;
      int ri;
      for (int k = 0; k < 7; k++) expBag[k] = 3'(k);
      l = stepL(stepL(mLfsr[d], tapsOf(d)), tapsOf(d));
      t = 2;
      for (int i = 6; i >= 1; i--) begin
         while (int'(l[2:0]) > i && t < 1000) begin
            l = stepL(l, tapsOf(d));
            t++;
         end
         ri = int'(l[2:0]);
         tmp = expBag[i];
         expBag[i] = expBag[ri];
         expBag[ri] = tmp;
         l = stepL(stepL(l, tapsOf(d)), tapsOf(d));
         t += 2;
      end
      expLat = t;
   endtask

   task automatic readBag(input int d);
      for (int k = 0; k < 7; k++) begin
         idx[d] = 3'(k);
         #1;
         obsBag[k] = piece[d];
      end
   endtask

   // Entered at a negedge with the DUT in IDLE. It runs one full request,
   // leaves the DUT in the following IDLE cycle, and returns at that
   // cycle's negedge.
   task automatic runBag(input int d, input int stallAt, input bit keepHigh);
      int cnt;
      int stallLen;
      bit seen;
      logic [15:0] snap;
      logic [6:0][2:0] snapBag;
      stallLen = 0;
      seen = 1'b0;
      cnt = 0;
      gen[d] = 1'b1;
      predict(d);
      while (!seen && cnt < 400) begin
         @(negedge clk);
         cnt++;
         if (done[d]) begin
            seen = 1'b1;
         end else if (cnt == stallAt) begin
            en[d] = 1'b0;
            snap = getLfsr(d);
            readBag(d);
            snapBag = obsBag;
            repeat (5) begin
               @(negedge clk);
               cnt++;
               stallLen++;
               nTests++;
               if (getLfsr(d) !== snap || busy[d] !== 1'b1 || done[d] !== 1'b0) begin
                  nFail++;
                  $display("FAIL stall_hold d=%0d lfsr=%h exp=%h busy=%b done=%b exp busy=1 done=0",
                           d, getLfsr(d), snap, busy[d], done[d]);
               end
            end
            readBag(d);
            nTests++;
            if (obsBag !== snapBag) begin
               nFail++;
               $display("FAIL stall_bag d=%0d got=%h exp=%h", d, obsBag, snapBag);
            end
            en[d] = 1'b1;
         end
      end
      lastLat = cnt;
      nTests++;
      if (!seen || cnt != expLat + stallLen) begin
         nFail++;
         $display("FAIL latency d=%0d seen=%b got=%0d exp=%0d", d, seen, cnt, expLat + stallLen);
      end
      if (seen) begin
         readBag(d);
         nTests++;
         if (obsBag !== expBag || busy[d] !== 1'b1) begin
            nFail++;
            $display("FAIL bag d=%0d got=%h exp=%h busy=%b", d, obsBag, expBag, busy[d]);
         end
         nTests++;
         if (!isPerm(obsBag)) begin
            nFail++;
            $display("FAIL permutation d=%0d got=%h exp=any permutation of 0..6", d, obsBag);
         end
      end
      if (!keepHigh) gen[d] = 1'b0;
      @(negedge clk);
      nTests++;
      if (done[d] !== 1'b0 || busy[d] !== 1'b0) begin
         nFail++;
         $display("FAIL done_width d=%0d done=%b busy=%b exp done=0 busy=0", d, done[d], busy[d]);
      end
   endtask

   task automatic test_reset();
      for (int k = 0; k < 8; k++) begin
         idx[0] = 3'(k);
         #1;
         nTests++;
         if (piece[0] !== 3'(k) || done[0] !== 1'b0 || busy[0] !== 1'b0) begin
            nFail++;
            $display("FAIL reset_read idx=%0d piece=%0d exp=%0d done=%b busy=%b", k, piece[0], k,
                     done[0], busy[0]);
         end
      end
      nTests++;
      if (getLfsr(0) !== 16'hACE1) begin
         nFail++;
         $display("FAIL reset_lfsr got=%h exp=ace1", getLfsr(0));
      end
      repeat (3) @(negedge clk);
      nTests++;
      if (done[0] !== 1'b0 || busy[0] !== 1'b0) begin
         nFail++;
         $display("FAIL idle_no_request done=%b busy=%b exp 0 0", done[0], busy[0]);
      end
   endtask

   task automatic test_zero_taps();
      logic [6:0][2:0] want;
      int bad;
      want = {3'd0, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1};
      rst[1] = 1'b1;
      @(negedge clk);
      rst[1] = 1'b0;
      @(negedge clk);
      runBag(1, -1, 1'b0);
      nTests++;
      if (lastLat != 14) begin
         nFail++;
         $display("FAIL zero_taps_latency got=%0d exp=14", lastLat);
      end
      readBag(1);
      nTests++;
      if (obsBag !== want) begin
         nFail++;
         $display("FAIL zero_taps_bag got=%h exp=%h", obsBag, want);
      end
      bad = 0;
      repeat (5) begin
         @(negedge clk);
         if (busy[1] !== 1'b0 || done[1] !== 1'b0) bad++;
      end
      nTests++;
      if (bad != 0) begin
         nFail++;
         $display("FAIL zero_taps_stays_idle bad_cycles=%0d exp=0", bad);
      end
   endtask

   task automatic test_back_to_back();
      bit keep;
      int gap;
      for (int b = 0; b < 200; b++) begin
         keep = (b != 199) && ($urandom_range(0, 3) != 0);
         runBag(0, -1, keep);
         if (!keep) begin
            gap = $urandom_range(0, 3);
            repeat (gap) @(negedge clk);
         end
      end
   endtask

   task automatic test_stall();
      runBag(0, 2, 1'b0);
   endtask

   task automatic test_reset_mid_swap();
      logic [6:0][2:0] ident;
      int bad;
      ident = {3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
      gen[1] = 1'b1;
      repeat (9) @(negedge clk);
      nTests++;
      if (busy[1] !== 1'b1 || dutZero.pickI !== 3'd3) begin
         nFail++;
         $display("FAIL mid_swap_setup busy=%b i=%0d exp busy=1 i=3", busy[1], dutZero.pickI);
      end
      rst[1] = 1'b1;
      gen[1] = 1'b0;
      @(negedge clk);
      rst[1] = 1'b0;
      nTests++;
      if (busy[1] !== 1'b0 || done[1] !== 1'b0 || getLfsr(1) !== 16'h0001) begin
         nFail++;
         $display("FAIL mid_swap_reset busy=%b done=%b lfsr=%h exp 0 0 0001",
                  busy[1], done[1], getLfsr(1));
      end
      readBag(1);
      nTests++;
      if (obsBag !== ident) begin
         nFail++;
         $display("FAIL mid_swap_bag got=%h exp=%h", obsBag, ident);
      end
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (done[1] !== 1'b0 || busy[1] !== 1'b0) bad++;
      end
      nTests++;
      if (bad != 0) begin
         nFail++;
         $display("FAIL mid_swap_no_done bad_cycles=%0d exp=0", bad);
      end
   endtask

   task automatic test_seed_zero();
      rst[2] = 1'b1;
      @(negedge clk);
      rst[2] = 1'b0;
      nTests++;
      if (getLfsr(2) !== 16'h0001) begin
         nFail++;
         $display("FAIL seed_zero_reset got=%h exp=0001", getLfsr(2));
      end
      @(negedge clk);
      nTests++;
      if (getLfsr(2) !== 16'hB400) begin
         nFail++;
         $display("FAIL seed_zero_step got=%h exp=b400", getLfsr(2));
      end
      runBag(2, -1, 1'b0);
   endtask

   initial begin
      for (int d = 0; d < 3; d++) begin
         rst[d] = 1'b1;
         en[d]  = 1'b1;
         gen[d] = 1'b0;
         idx[d] = 3'd0;
      end
      repeat (3) @(negedge clk);
      for (int d = 0; d < 3; d++) rst[d] = 1'b0;
      test_reset();
      test_zero_taps();
      test_back_to_back();
      test_stall();
      test_reset_mid_swap();
      test_seed_zero();
      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog simulation time limit reached tests=%0d", nTests);
      $fatal(1, "watchdog");
   end

endmodule
